// File: rtl/main_stream_pkg.sv
// ============================================================================
// Module      : main_stream_pkg
// Description : Shared state encoding and symbol constants for the main-stream
//               scheduler and its benches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package main_stream_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_IDLE_RUN  = 2'b01,
    ST_VID_RUN   = 2'b10,
    ST_VID_DRAIN = 2'b11
  } sched_state_t;

  localparam logic [7:0] SR = 8'h0F;
  localparam logic [7:0] BS = 8'hBC;
  localparam logic [7:0] BF = 8'hBD;

endpackage

`default_nettype wire

// File: rtl/sched_src_mux.sv
// ============================================================================
// Module      : sched_src_mux
// Description : Delays each source enable by the source latency and muxes the
//               matching source onto a registered symbol/flag output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_src_mux
  import main_stream_pkg::*;
#(
  parameter int SRC_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_idle_en,
  input  logic       i_vid_en,
  input  logic [7:0] i_idle_sym,
  input  logic       i_idle_flag,
  input  logic [7:0] i_vid_sym,
  input  logic       i_vid_flag,
  output logic [7:0] o_sym,
  output logic       o_flag
);

  logic [SRC_LAT-1:0] r_idle_sel;
  logic [SRC_LAT-1:0] r_vid_sel;
  logic               w_idle_tap;
  logic               w_vid_tap;
  logic [7:0]         r_sym;
  logic               r_flag;

  assign w_idle_tap = r_idle_sel[SRC_LAT-1];
  assign w_vid_tap  = r_vid_sel[SRC_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_sel <= '0;
      r_vid_sel  <= '0;
    end else if (i_flush) begin
      r_idle_sel <= '0;
      r_vid_sel  <= '0;
    end else begin
      r_idle_sel[0] <= i_idle_en;
      r_vid_sel[0]  <= i_vid_en;
      for (int i = 1; i < SRC_LAT; i++) begin
        r_idle_sel[i] <= r_idle_sel[i-1];
        r_vid_sel[i]  <= r_vid_sel[i-1];
      end
    end
  end

  // The output stage still uses the current taps on a flush edge, so the
  // last in-flight symbol drains before the output goes quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym  <= 8'h00;
      r_flag <= 1'b0;
    end else if (w_idle_tap) begin
      r_sym  <= i_idle_sym;
      r_flag <= i_idle_flag;
    end else if (w_vid_tap) begin
      r_sym  <= i_vid_sym;
      r_flag <= i_vid_flag;
    end else begin
      r_sym  <= 8'h00;
      r_flag <= 1'b0;
    end
  end

  a_sel_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(w_idle_tap && w_vid_tap));

  assign o_sym  = r_sym;
  assign o_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/main_stream_scheduler.sv
// ============================================================================
// Module      : main_stream_scheduler
// Description : Selects between the idle pattern generator and the video path,
//               switching only at source-permitted boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_stream_scheduler
  import main_stream_pkg::*;
#(
  parameter int MIN_IDLE_CYCLES = 16,
  parameter int SWITCH_TIMEOUT  = 8192,
  parameter int SRC_LAT         = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_ready,
  input  logic       vid_stream_req,
  input  logic       idle_activate_en,
  input  logic       vid_activate_en,
  input  logic [7:0] idle_symbols,
  input  logic       idle_control_sym_flag,
  input  logic [7:0] vid_symbols,
  input  logic       vid_control_sym_flag,
  output logic       sched_idle_en,
  output logic       sched_vid_en,
  output logic [7:0] sched_symbols,
  output logic       sched_control_sym_flag,
  output logic [1:0] sched_state,
  output logic       sched_switch_err
);

  localparam int c_dwell_w = $clog2(MIN_IDLE_CYCLES + 1);
  localparam int c_to_w    = $clog2(SWITCH_TIMEOUT + 1);
  localparam logic [c_dwell_w-1:0] c_dwell_max = c_dwell_w'(MIN_IDLE_CYCLES);
  localparam logic [c_to_w-1:0]    c_to_last   = c_to_w'(SWITCH_TIMEOUT - 1);

  sched_state_t         r_state;
  sched_state_t         w_next;
  logic                 w_timeout;
  logic [c_dwell_w-1:0] r_dwell;
  logic [c_to_w-1:0]    r_to_cnt;
  logic                 r_switch_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_OFF;
      r_switch_err <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_switch_err <= w_timeout;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    if (!link_ready) begin
      w_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:      w_next = ST_IDLE_RUN;
        ST_IDLE_RUN: begin
          if (vid_stream_req && (r_dwell == c_dwell_max) && idle_activate_en)
            w_next = ST_VID_RUN;
        end
        ST_VID_RUN: begin
          if (!vid_stream_req)
            w_next = ST_VID_DRAIN;
        end
        ST_VID_DRAIN: begin
          // A renewed request cancels the drain before any switch-away.
          if (vid_stream_req) begin
            w_next = ST_VID_RUN;
          end else if (vid_activate_en) begin
            w_next = ST_IDLE_RUN;
          end else if (r_to_cnt == c_to_last) begin
            w_next    = ST_IDLE_RUN;
            w_timeout = 1'b1;
          end
        end
        default:     w_next = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
    end else if (!link_ready || r_state != ST_IDLE_RUN || w_next != ST_IDLE_RUN) begin
      r_dwell <= '0;
    end else if (r_dwell != c_dwell_max) begin
      r_dwell <= r_dwell + c_dwell_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!link_ready || r_state != ST_VID_DRAIN || w_next != ST_VID_DRAIN) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_to_last) begin
      r_to_cnt <= r_to_cnt + c_to_w'(1);
    end
  end

  assign sched_idle_en    = (r_state == ST_IDLE_RUN);
  assign sched_vid_en     = (r_state == ST_VID_RUN) || (r_state == ST_VID_DRAIN);
  assign sched_state      = r_state;
  assign sched_switch_err = r_switch_err;

  sched_src_mux #(
    .SRC_LAT (SRC_LAT)
  ) u_src_mux (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (!link_ready),
    .i_idle_en   (sched_idle_en),
    .i_vid_en    (sched_vid_en),
    .i_idle_sym  (idle_symbols),
    .i_idle_flag (idle_control_sym_flag),
    .i_vid_sym   (vid_symbols),
    .i_vid_flag  (vid_control_sym_flag),
    .o_sym       (sched_symbols),
    .o_flag      (sched_control_sym_flag)
  );

endmodule

`default_nettype wire

// File: tb/tb_main_stream_scheduler.sv
// ============================================================================
// Module      : tb_main_stream_scheduler
// Description : Directed bench with a symbol scoreboard for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_stream_scheduler;
  import main_stream_pkg::*;

  localparam int MIN_IDLE = 16;
  localparam int TO       = 8;
  localparam int LAT      = 2;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_IDLE = 2'd1;
  localparam logic [1:0] T_VID  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       link_ready = 1'b0;
  logic       vid_stream_req = 1'b0;
  logic       idle_activate_en = 1'b0;
  logic       vid_activate_en = 1'b0;
  logic [7:0] idle_symbols = SR;
  logic       idle_control_sym_flag = 1'b1;
  logic [7:0] vid_symbols = 8'h00;
  logic       vid_control_sym_flag = 1'b0;
  logic       sched_idle_en;
  logic       sched_vid_en;
  logic [7:0] sched_symbols;
  logic       sched_control_sym_flag;
  logic [1:0] sched_state;
  logic       sched_switch_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  main_stream_scheduler #(
    .MIN_IDLE_CYCLES (MIN_IDLE),
    .SWITCH_TIMEOUT  (TO),
    .SRC_LAT         (LAT)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .link_ready             (link_ready),
    .vid_stream_req         (vid_stream_req),
    .idle_activate_en       (idle_activate_en),
    .vid_activate_en        (vid_activate_en),
    .idle_symbols           (idle_symbols),
    .idle_control_sym_flag  (idle_control_sym_flag),
    .vid_symbols            (vid_symbols),
    .vid_control_sym_flag   (vid_control_sym_flag),
    .sched_idle_en          (sched_idle_en),
    .sched_vid_en           (sched_vid_en),
    .sched_symbols          (sched_symbols),
    .sched_control_sym_flag (sched_control_sym_flag),
    .sched_state            (sched_state),
    .sched_switch_err       (sched_switch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: capture source values at the edge, check state/enables/error,
  // then score the output symbol against the entry pushed LAT+1 cycles ago.
  task automatic cyc(input sched_state_t exp_st, input logic exp_err = 1'b0);
    logic [8:0] s_idle;
    logic [8:0] s_vid;
    logic       s_link;
    logic [1:0] tag;
    s_idle = {idle_control_sym_flag, idle_symbols};
    s_vid  = {vid_control_sym_flag, vid_symbols};
    s_link = link_ready;
    @(posedge clk);
    #1;
    chk("state",    9'(sched_state),      9'(exp_st));
    chk("idle_en",  9'(sched_idle_en),    9'(exp_st == ST_IDLE_RUN));
    chk("vid_en",   9'(sched_vid_en),     9'(exp_st == ST_VID_RUN || exp_st == ST_VID_DRAIN));
    chk("sw_err",   9'(sched_switch_err), 9'(exp_err));
    if (exp_st == ST_IDLE_RUN)
      exp_q.push_back(T_IDLE);
    else if (exp_st == ST_VID_RUN || exp_st == ST_VID_DRAIN)
      exp_q.push_back(T_VID);
    else
      exp_q.push_back(T_NONE);
    tag = exp_q.pop_front();
    chk("symbol", {sched_control_sym_flag, sched_symbols},
        (tag == T_IDLE) ? s_idle : (tag == T_VID) ? s_vid : 9'h000);
    if (!s_link)
      foreach (exp_q[i]) exp_q[i] = T_NONE;
    vid_symbols          = 8'($urandom_range(0, 255));
    vid_control_sym_flag = 1'($urandom_range(0, 1));
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_state",  9'(sched_state),  9'h000);
    chk("rst_idle",   9'(sched_idle_en), 9'h000);
    chk("rst_vid",    9'(sched_vid_en),  9'h000);
    chk("rst_sym",    {sched_control_sym_flag, sched_symbols}, 9'h000);
    chk("rst_err",    9'(sched_switch_err), 9'h000);
    for (int i = 0; i < LAT + 1; i++) exp_q.push_back(T_NONE);
    #10 rst_n = 1'b1;
    cyc(ST_OFF);

    // Bring-up and dwell gating: request held from the first IDLE_RUN cycle
    link_ready       = 1'b1;
    vid_stream_req   = 1'b1;
    idle_activate_en = 1'b1;
    cyc(ST_IDLE_RUN);
    for (int i = 0; i < MIN_IDLE; i++) cyc(ST_IDLE_RUN);
    cyc(ST_VID_RUN);
    for (int i = 0; i < 3; i++) cyc(ST_VID_RUN);

    // Drain then cancel
    vid_stream_req = 1'b0;
    for (int i = 0; i < 3; i++) cyc(ST_VID_DRAIN);
    vid_stream_req = 1'b1;
    cyc(ST_VID_RUN);
    cyc(ST_VID_RUN);

    // Drain completed by the video path's availability flag
    vid_stream_req = 1'b0;
    cyc(ST_VID_DRAIN);
    vid_activate_en = 1'b1;
    cyc(ST_IDLE_RUN);
    vid_activate_en = 1'b0;

    // Availability gating: dwell expires, idle generator withholds permission
    vid_stream_req   = 1'b1;
    idle_activate_en = 1'b0;
    for (int i = 0; i < MIN_IDLE + 5; i++) cyc(ST_IDLE_RUN);
    idle_activate_en = 1'b1;
    cyc(ST_VID_RUN);
    cyc(ST_VID_RUN);

    // Drain timeout
    vid_stream_req = 1'b0;
    for (int i = 0; i < TO; i++) cyc(ST_VID_DRAIN);
    cyc(ST_IDLE_RUN, 1'b1);
    cyc(ST_IDLE_RUN, 1'b0);

    // Back to video, then drop the link
    vid_stream_req = 1'b1;
    for (int i = 0; i < MIN_IDLE - 1; i++) cyc(ST_IDLE_RUN);
    cyc(ST_VID_RUN);
    cyc(ST_VID_RUN);
    cyc(ST_VID_RUN);
    link_ready = 1'b0;
    cyc(ST_OFF);
    cyc(ST_OFF);
    cyc(ST_OFF);

    // Relink
    link_ready     = 1'b1;
    vid_stream_req = 1'b0;
    for (int i = 0; i < 5; i++) cyc(ST_IDLE_RUN);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 9'(sched_state),   9'h000);
    chk("arst_idle",  9'(sched_idle_en), 9'h000);
    chk("arst_sym",   {sched_control_sym_flag, sched_symbols}, 9'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
